// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with registered (or FWFT) read port
// Optional feature macro: FIFO_FWFT_EN (first-word fall-through read port)
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   wr_en, data_in    write request and data; full/almost_full report free space
//   rd_en             read request (acknowledge/pop in FWFT mode)
//   data_out, rd_valid  read data and its valid strobe
//   empty, almost_empty, fifo_words  occupancy status
//   overflow, underflow, clr_err     sticky error flags and their clear
module sync_fifo_param #(
   parameter int DATA_W    = 8,
   parameter int DEPTH     = 8,
   parameter int AF_THRESH = DEPTH - 1,
   parameter int AE_THRESH = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [DATA_W-1:0]        data_in,
   output logic                     full,
   output logic                     almost_full,
   input  logic                     rd_en,
   output logic [DATA_W-1:0]        data_out,
   output logic                     rd_valid,
   output logic                     empty,
   output logic                     almost_empty,
   output logic [$clog2(DEPTH):0]   fifo_words,
   output logic                     overflow,
   output logic                     underflow,
   input  logic                     clr_err
);
   localparam int ADDR_W = $clog2(DEPTH);
   localparam logic [ADDR_W:0] AF  = AF_THRESH[ADDR_W:0];
   localparam logic [ADDR_W:0] AE  = AE_THRESH[ADDR_W:0];
   localparam logic [ADDR_W:0] ONE = 1;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W:0]   wr_ptr, rd_ptr;
   logic              rd_acc, wr_acc;
   // pointers carry one extra wrap bit so all DEPTH entries are usable
   assign empty        = wr_ptr == rd_ptr;
   assign full         = wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0] && wr_ptr[ADDR_W] != rd_ptr[ADDR_W];
   assign fifo_words   = wr_ptr - rd_ptr;
   assign almost_full  = fifo_words >= AF;
   assign almost_empty = fifo_words <= AE;
   assign rd_acc       = rd_en && !empty;
   // a full FIFO still takes a write when a read frees the head in the same cycle
   assign wr_acc       = wr_en && (!full || rd_acc);
   always_ff @(posedge clk)
      if (wr_acc) mem[wr_ptr[ADDR_W-1:0]] <= data_in;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + ONE;
         if (rd_acc) rd_ptr <= rd_ptr + ONE;
         // a new error wins over a coincident clear
         overflow  <= (wr_en && !wr_acc) || (overflow && !clr_err);
         underflow <= (rd_en && empty) || (underflow && !clr_err);
      end
   end
`ifdef FIFO_FWFT_EN
   assign data_out = mem[rd_ptr[ADDR_W-1:0]];
   assign rd_valid = !empty;
`else
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         data_out <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= rd_acc;
         if (rd_acc) data_out <= mem[rd_ptr[ADDR_W-1:0]];
      end
   end
`endif
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: queue-model and directed-literal check of sync_fifo_param
module tb_sync_fifo_param;
   localparam int DEPTH = 8;
   logic       clk = 1'b0, rst_n = 1'b0;
   logic       wr_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
   logic [7:0] data_in = '0;
   logic [7:0] data_out;
   logic       full, almost_full, rd_valid, empty, almost_empty, overflow, underflow;
   logic [3:0] fifo_words;
   int         total = 0, bad = 0;
   logic       chk_en = 1'b0;
   logic [7:0] q [$];
   logic [7:0] m_dout = '0;
   logic       m_valid = 1'b0, m_ovf = 1'b0, m_unf = 1'b0;

   sync_fifo_param #(.DATA_W(8), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .data_in(data_in), .full(full),
      .almost_full(almost_full), .rd_en(rd_en), .data_out(data_out), .rd_valid(rd_valid),
      .empty(empty), .almost_empty(almost_empty), .fifo_words(fifo_words),
      .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // reference behaviour: occupancy is the queue length, reads pop the front
   always @(posedge clk) begin
      int n;
      logic ra, wa;
      if (!rst_n) begin
         q.delete();
         m_dout = '0;
         m_valid = 1'b0;
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else begin
         n = q.size();
         ra = rd_en && n > 0;
         wa = wr_en && (n < DEPTH || ra);
         m_ovf = (wr_en && !wa) || (m_ovf && !clr_err);
         m_unf = (rd_en && n == 0) || (m_unf && !clr_err);
         m_valid = ra;
         if (ra) m_dout = q.pop_front();
         if (wa) q.push_back(data_in);
      end
   end

   always @(negedge clk) begin
      int n;
      if (chk_en) begin
         n = q.size();
         chk("full", full, n == DEPTH);
         chk("empty", empty, n == 0);
         chk("fifo_words", fifo_words, n);
         chk("almost_full", almost_full, n >= DEPTH - 1);
         chk("almost_empty", almost_empty, n <= 1);
         chk("overflow", overflow, m_ovf);
         chk("underflow", underflow, m_unf);
`ifdef FIFO_FWFT_EN
         chk("rd_valid", rd_valid, n != 0);
         if (n != 0) chk("data_out", data_out, q[0]);
`else
         chk("rd_valid", rd_valid, m_valid);
         chk("data_out", data_out, m_dout);
`endif
      end
   end

   task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
      wr_en = w;
      data_in = d;
      rd_en = r;
      clr_err = c;
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      rd_en = 1'b0;
      clr_err = 1'b0;
   endtask

   initial begin
      @(posedge clk);
      #1;
      chk_en = 1'b1;
      rst_n = 1'b1;
      step(0, 0, 0, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_words", fifo_words, 0);
      chk("rst_ae", almost_empty, 1);
      chk("rst_valid", rd_valid, 0);
`ifndef FIFO_FWFT_EN
      chk("rst_dout", data_out, 0);
`endif
      chk("rst_ovf", overflow, 0);
      chk("rst_unf", underflow, 0);
      for (int i = 0; i < 8; i++) begin
         step(1, 8'((i + 1) * 8'h11), 0, 0);
         chk("fill_words", fifo_words, i + 1);
         if (i == 5) chk("af_at6", almost_full, 0);
         if (i == 6) chk("af_at7", almost_full, 1);
      end
      chk("fill_full", full, 1);
      step(1, 8'h99, 0, 0);
      chk("ovf_set", overflow, 1);
      chk("ovf_words", fifo_words, 8);
      for (int i = 0; i < 8; i++) begin
         step(0, 0, 1, 0);
`ifndef FIFO_FWFT_EN
         chk("drain_valid", rd_valid, 1);
         chk("drain_data", data_out, (i + 1) * 8'h11);
`endif
      end
      step(0, 0, 0, 1);
      chk("drain_empty", empty, 1);
      chk("drain_valid_off", rd_valid, 0);
      chk("clr_ovf", overflow, 0);
      for (int i = 0; i < 5; i++) step(1, 8'(8'h21 + i), 0, 0);
      for (int i = 0; i < 5; i++) begin
         step(0, 0, 1, 0);
`ifndef FIFO_FWFT_EN
         chk("wrap5_data", data_out, 8'h21 + i);
`endif
      end
      for (int i = 0; i < 8; i++) step(1, 8'(8'hC1 + i), 0, 0);
      chk("wrap_full", full, 1);
      chk("wrap_words", fifo_words, 8);
      for (int i = 0; i < 8; i++) begin
         step(0, 0, 1, 0);
`ifndef FIFO_FWFT_EN
         chk("wrap8_data", data_out, 8'hC1 + i);
`endif
         chk("wrap8_words", fifo_words, 7 - i);
      end
      for (int i = 0; i < 8; i++) step(1, 8'(8'h41 + i), 0, 0);
      step(1, 8'hA5, 1, 0);
      chk("simul_words", fifo_words, 8);
      chk("simul_ovf", overflow, 0);
`ifndef FIFO_FWFT_EN
      chk("simul_data", data_out, 8'h41);
`endif
      for (int i = 0; i < 8; i++) begin
         step(0, 0, 1, 0);
`ifndef FIFO_FWFT_EN
         chk("simul_drain", data_out, i == 7 ? 8'hA5 : 8'h42 + i);
`endif
      end
      step(1, 8'h3C, 1, 0);
      chk("emp_unf", underflow, 1);
      chk("emp_words", fifo_words, 1);
`ifndef FIFO_FWFT_EN
      chk("emp_valid", rd_valid, 0);
`endif
      step(0, 0, 1, 0);
`ifndef FIFO_FWFT_EN
      chk("emp_data", data_out, 8'h3C);
`endif
      step(0, 0, 0, 1);
      chk("clr_unf", underflow, 0);
      chk("clr_ovf2", overflow, 0);
      for (int i = 0; i < 5; i++) step(1, 8'(8'h61 + i), 0, 0);
      chk("mid_words", fifo_words, 5);
      rst_n = 1'b0;
      step(0, 0, 0, 0);
      rst_n = 1'b1;
      chk("mid_empty", empty, 1);
      chk("mid_words0", fifo_words, 0);
      chk("mid_valid", rd_valid, 0);
      step(1, 8'h77, 0, 0);
      step(0, 0, 1, 0);
`ifndef FIFO_FWFT_EN
      chk("post_rst_data", data_out, 8'h77);
`endif
      step(0, 0, 0, 0);
      chk("post_rst_empty", empty, 1);
      for (int i = 0; i < 60; i++) step(i % 3 != 0, 8'(i * 7 + 1), i % 2 == 0 || i > 40, i % 17 == 0);
      step(0, 0, 0, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised synchronous FIFO, the next generation of the team's 8x8 byte FIFO: configurable data width and depth, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, and a registered read port with a valid strobe. Sits between producer/consumer blocks in the same clock domain (UART/SPI byte streams, sample buffers). Single clock. Storage is an inferred register array.

Parameters:
DATA_W, 8, data word width in bits (>=1)
DEPTH, 8, number of storage entries; power of two, >=2
AF_THRESH, DEPTH-1, almost_full asserted when fifo_words >= AF_THRESH
AE_THRESH, 1, almost_empty asserted when fifo_words <= AE_THRESH

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  synchronous reset, active-low
wr_en  input  1  write request
data_in  input  DATA_W  write data
full  output  1  no free entry
almost_full  output  1  fifo_words >= AF_THRESH
rd_en  input  1  read request
data_out  output  DATA_W  read data
rd_valid  output  1  data_out carries the word of an accepted read
empty  output  1  no stored entry
almost_empty  output  1  fifo_words <= AE_THRESH
fifo_words  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: write attempted while refused
underflow  output  1  sticky: read attempted while empty
clr_err  input  1  clears overflow/underflow

Behaviour:
- Reset is rst_n, synchronous, active-low; clock clk. When rst_n=0 at an edge: pointers=0, fifo_words=0, data_out=0, rd_valid=0, overflow=0, underflow=0. Memory contents are not reset.
- Pointers: ADDR_W=$clog2(DEPTH) plus one wrap bit. empty = pointers equal. full = address bits equal and wrap bits differ. Every full DEPTH-multiple of traffic wraps with no dead entry; all DEPTH entries are usable.
- fifo_words = wr_ptr - rd_ptr, width ADDR_W+1, modulo arithmetic. full, empty, almost_full and almost_empty are combinational from the registered pointers.
- Read accept: rd_acc = rd_en && !empty.
- Write accept: wr_acc = wr_en && (!full || rd_acc). When full, a write is accepted in the same cycle as an accepted read; occupancy is unchanged.
- Empty with rd_en and wr_en both high: the write is accepted and the read is refused. underflow is set. The written word becomes readable next cycle.
- Accepted write: mem[wr_ptr[ADDR_W-1:0]] <= data_in; wr_ptr increments at the edge.
- Accepted read: data_out <= mem[rd_ptr]; rd_ptr increments; rd_valid=1 for exactly the next cycle. Latency is 1 clock from rd_en edge to data.
- Refused or no read: rd_valid=0 and data_out holds its last value.
- overflow is set on wr_en && !wr_acc. underflow is set on rd_en && empty.
- Both flags stay set until clr_err=1 or reset. If clr_err and a new error coincide in the same cycle, set wins.
- Data order is strict FIFO. No word is duplicated or lost under any rd_en/wr_en pattern.

Optional Feature:
FIFO_FWFT_EN
- Defined (first-word fall-through):
  - data_out = mem[rd_ptr] combinationally whenever !empty.
  - rd_valid = !empty.
  - rd_en acts as an acknowledge: it pops the head, and the next word appears in the same cycle the pointer updates.
  - data_out after reset is don't-care while empty.
  - Accept rules and flags are unchanged.
- Undefined: registered 1-cycle read as described in Behaviour.

Test Plan:
- Reset, then idle: empty=1, full=0, fifo_words=0, almost_empty=1, rd_valid=0, data_out=0, overflow=0, underflow=0.
- DEPTH=8, write 0x11..0x88 on 8 consecutive cycles: full=1, fifo_words=8, almost_full from fifo_words=7. A 9th write of 0x99 is refused and sets overflow=1. Read 8 times: data_out 0x11..0x88, each one cycle after its rd_en with rd_valid=1, then empty=1.
- Wrap: write 5, read 5, write 8, read 8: all values returned in order, fifo_words tracks 0..8 correctly across the pointer wrap.
- Full plus simultaneous rd_en/wr_en with 0xA5: head word is read, 0xA5 is stored, fifo_words stays 8, overflow not set.
- Empty plus simultaneous rd_en/wr_en with 0x3C: underflow=1, rd_valid=0, fifo_words=1. Next read returns 0x3C. Pulse clr_err: both error flags return to 0.
- Reset asserted mid-stream with fifo_words=5: next cycle empty=1, fifo_words=0, rd_valid=0. A subsequent write/read returns the new data only.
